// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin tie-break, bounded hold while the other master waits,
// combinational bus mux toward the bridge and registered per-master read return.
module bus_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_wen,
    input  logic        m1_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] Bus_addr,
    output logic [31:0] Bus_wdata,
    output logic        Bus_wen,
    input  logic [31:0] Bus_rdata,
    output logic [1:0]  owner
);

    // State codes double as the owner encoding, so gnt/owner come straight off the register.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] hold_cnt_r;
    logic [7:0] hold_cnt_nxt_s;
    logic       last_r;
    logic       last_nxt_s;
    logic       acc0_s;
    logic       acc1_s;

    assign acc0_s = (state_r == OWN0) && m0_req;
    assign acc1_s = (state_r == OWN1) && m1_req;

    assign m0_gnt = state_r[0];
    assign m1_gnt = state_r[1];
    assign owner  = state_r;

    // State, hold counter and last-served pointer registers
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_r    <= IDLE;
            hold_cnt_r <= 8'd0;
            last_r     <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            last_r     <= last_nxt_s;
        end
    end

    // Next-state arbitration; last_r=1 means m1 was served last, so m0 wins a tie
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt_s = last_r ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_nxt_s = OWN0;
                end else if (m1_req) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    state_nxt_s = m1_req ? OWN1 : IDLE;
                end else if (m1_req && (hold_cnt_r == HOLD_LAST)) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = OWN0;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_nxt_s = m0_req ? OWN0 : IDLE;
                end else if (m0_req && (hold_cnt_r == HOLD_LAST)) begin
                    state_nxt_s = OWN0;
                end else begin
                    state_nxt_s = OWN1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Hold counter restarts on any ownership change and saturates one below the limit
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        if (state_nxt_s != state_r) begin
            hold_cnt_nxt_s = 8'd0;
        end else if ((acc0_s || acc1_s) && (hold_cnt_r != HOLD_LAST)) begin
            hold_cnt_nxt_s = hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end
    end

    // Pointer follows whichever master is about to own the bus
    always_comb begin
        last_nxt_s = last_r;
        if (state_nxt_s == OWN0) begin
            last_nxt_s = 1'b0;
        end else if (state_nxt_s == OWN1) begin
            last_nxt_s = 1'b1;
        end else begin
            last_nxt_s = last_r;
        end
    end

    // Shared bus mux: driven only during an access, otherwise held at zero
    always_comb begin
        Bus_addr  = 32'h0000_0000;
        Bus_wdata = 32'h0000_0000;
        Bus_wen   = 1'b0;
        if (acc0_s) begin
            Bus_addr  = m0_addr;
            Bus_wdata = m0_wdata;
            Bus_wen   = m0_wen;
        end else if (acc1_s) begin
            Bus_addr  = m1_addr;
            Bus_wdata = m1_wdata;
            Bus_wen   = m1_wen;
        end else begin
            Bus_addr  = 32'h0000_0000;
            Bus_wdata = 32'h0000_0000;
            Bus_wen   = 1'b0;
        end
    end

    // Read return: capture bridge data on a read access, pulse rvalid one cycle later
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 32'h0000_0000;
            m1_rdata  <= 32'h0000_0000;
        end else begin
            m0_rvalid <= acc0_s && !m0_wen;
            m1_rvalid <= acc1_s && !m1_wen;
            if (acc0_s && !m0_wen) begin
                m0_rdata <= Bus_rdata;
            end
            if (acc1_s && !m1_wen) begin
                m1_rdata <= Bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a cycle-level model of the arbitration rules.
module tb_bus_arbiter;
    localparam int HOLD = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        m0_req, m1_req, m0_wen, m1_wen;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, Bus_rdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, Bus_wen;
    logic [31:0] m0_rdata, m1_rdata, Bus_addr, Bus_wdata;
    logic [1:0]  owner;

    bus_arbiter #(.HOLD_MAX(HOLD)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wen(m0_wen), .m1_wen(m1_wen),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .Bus_addr(Bus_addr), .Bus_wdata(Bus_wdata), .Bus_wen(Bus_wen),
        .Bus_rdata(Bus_rdata), .owner(owner)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1, brd;
        logic [1:0]  e_own;
        logic        e_bwen;
        logic [31:0] e_baddr, e_bwdata;
        logic        e_rv0, e_rv1;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    vec_t tbl[11];

    // reference model state: owner -1 = none, 0 = m0, 1 = m1
    int          own, streak, last, nxt, acc_cnt;
    logic        rq[2], wn[2], mrv[2], acc, got;
    logic [31:0] ad[2], wd[2], mrd[2], brd_v;
    logic [31:0] e_baddr, e_bwdata;
    logic        e_bwen;
    logic [1:0]  e_own;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, r1, w0, w1, input logic [31:0] a0, a1, d0, d1, brd);
        m0_req = r0; m1_req = r1; m0_wen = w0; m1_wen = w1;
        m0_addr = a0; m1_addr = a1; m0_wdata = d0; m1_wdata = d1; Bus_rdata = brd;
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst owner", owner, 0);
        chk("rst m0_gnt", m0_gnt, 0);
        chk("rst m1_gnt", m1_gnt, 0);
        chk("rst rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst m0_rdata", m0_rdata, 0);
        chk("rst m1_rdata", m1_rdata, 0);
        chk("rst bus", {Bus_wen, Bus_addr | Bus_wdata}, 0);

        // r0 r1 w0 w1  a0  a1  d0  d1  brd | own bwen baddr bwdata rv0 rv1 rd0 rd1
        tbl[0]  = '{1,0,0,0, 32'h10,0,0,0, 32'h1234_5678, 2'b00,0,0,0, 0,0, 0,0};
        tbl[1]  = '{1,0,0,0, 32'h10,0,0,0, 32'h1234_5678, 2'b01,0,32'h10,0, 0,0, 0,0};
        tbl[2]  = '{0,0,0,0, 32'h10,0,0,0, 0, 2'b01,0,0,0, 1,0, 32'h1234_5678,0};
        tbl[3]  = '{0,0,0,0, 0,0,0,0,0, 2'b00,0,0,0, 0,0, 32'h1234_5678,0};
        tbl[4]  = '{0,1,0,1, 0,32'h20,0,32'hDEAD,0, 2'b00,0,0,0, 0,0, 32'h1234_5678,0};
        tbl[5]  = '{0,1,0,1, 0,32'h20,0,32'hDEAD,0, 2'b10,1,32'h20,32'hDEAD, 0,0, 32'h1234_5678,0};
        tbl[6]  = '{1,1,0,0, 0,32'h24,0,0,32'hCAFE_0001, 2'b10,0,32'h24,0, 0,0, 32'h1234_5678,0};
        tbl[7]  = '{1,0,0,0, 0,0,0,0,0, 2'b10,0,0,0, 0,1, 32'h1234_5678,32'hCAFE_0001};
        tbl[8]  = '{1,0,1,0, 32'h30,0,32'h55,0,0, 2'b01,1,32'h30,32'h55, 0,0, 32'h1234_5678,32'hCAFE_0001};
        tbl[9]  = '{0,0,0,0, 0,0,0,0,0, 2'b01,0,0,0, 0,0, 32'h1234_5678,32'hCAFE_0001};
        tbl[10] = '{0,0,0,0, 0,0,0,0,0, 2'b00,0,0,0, 0,0, 32'h1234_5678,32'hCAFE_0001};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1,
                  tbl[i].d0, tbl[i].d1, tbl[i].brd);
            @(negedge cpu_clk);
            chk($sformatf("row%0d owner", i), owner, tbl[i].e_own);
            chk($sformatf("row%0d m0_gnt", i), m0_gnt, tbl[i].e_own == 2'b01);
            chk($sformatf("row%0d m1_gnt", i), m1_gnt, tbl[i].e_own == 2'b10);
            chk($sformatf("row%0d Bus_wen", i), Bus_wen, tbl[i].e_bwen);
            chk($sformatf("row%0d Bus_addr", i), Bus_addr, tbl[i].e_baddr);
            chk($sformatf("row%0d Bus_wdata", i), Bus_wdata, tbl[i].e_bwdata);
            chk($sformatf("row%0d m0_rvalid", i), m0_rvalid, tbl[i].e_rv0);
            chk($sformatf("row%0d m1_rvalid", i), m1_rvalid, tbl[i].e_rv1);
            chk($sformatf("row%0d m0_rdata", i), m0_rdata, tbl[i].e_rd0);
            chk($sformatf("row%0d m1_rdata", i), m1_rdata, tbl[i].e_rd1);
            tick();
        end

        // simultaneous requests after reset: m0 first, then handover with no idle gap
        do_reset();
        drive(1, 1, 0, 0, 32'h40, 32'h44, 0, 0, 0);
        tick();
        @(negedge cpu_clk);
        chk("tie m0_gnt", m0_gnt, 1);
        chk("tie m1_gnt", m1_gnt, 0);
        tick();
        drive(0, 1, 0, 0, 32'h40, 32'h44, 0, 0, 0);
        tick();
        @(negedge cpu_clk);
        chk("handover m1_gnt", m1_gnt, 1);
        chk("handover m0_gnt", m0_gnt, 0);
        chk("handover owner", owner, 2'b10);

        // hold limit: m0 streams while m1 waits
        do_reset();
        drive(1, 1, 0, 0, 32'h100, 32'h200, 0, 0, 32'h77);
        acc_cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge cpu_clk);
            if (m1_gnt) got = 1'b1;
            else if (m0_gnt && m0_req) acc_cnt++;
            if (!got) tick();
        end
        chk("hold m1 granted", got, 1);
        chk("hold m0 accesses", acc_cnt, HOLD);
        tick();
        drive(1, 0, 0, 0, 32'h100, 32'h200, 0, 0, 32'h77);
        @(negedge cpu_clk);
        chk("hold m1 still owns", owner, 2'b10);
        tick();
        @(negedge cpu_clk);
        chk("hold back to m0", m0_gnt, 1);
        chk("hold m1 released", m1_gnt, 0);

        // lone m1 write stream: no preemption, no rvalid
        do_reset();
        drive(0, 1, 0, 1, 0, 32'h300, 0, 32'hA5A5_0000, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 1, 0, 32'h300 + 32'(4 * i), 0, 32'hA5A5_0000 + 32'(i), 0);
            @(negedge cpu_clk);
            chk($sformatf("wr%0d m1_gnt", i), m1_gnt, 1);
            chk($sformatf("wr%0d Bus_wen", i), Bus_wen, 1);
            chk($sformatf("wr%0d Bus_wdata", i), Bus_wdata, 32'hA5A5_0000 + 32'(i));
            chk($sformatf("wr%0d Bus_addr", i), Bus_addr, 32'h300 + 32'(4 * i));
            chk($sformatf("wr%0d m1_rvalid", i), m1_rvalid, 0);
            tick();
        end

        // reset in the middle of a read
        do_reset();
        drive(1, 0, 0, 0, 32'h500, 0, 0, 0, 32'hBEEF_0000);
        tick();
        @(negedge cpu_clk);
        chk("midrd m0_gnt before", m0_gnt, 1);
        chk("midrd Bus_addr before", Bus_addr, 32'h500);
        #2 cpu_rst_n = 1'b0;
        #1;
        chk("midrd m0_gnt", m0_gnt, 0);
        chk("midrd owner", owner, 0);
        chk("midrd Bus_wen", Bus_wen, 0);
        chk("midrd Bus_addr", Bus_addr, 0);
        tick();
        chk("midrd no rvalid", m0_rvalid, 0);
        chk("midrd rdata", m0_rdata, 0);
        drive(0, 1, 0, 0, 0, 32'h600, 0, 0, 0);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        #1;
        chk("release m1_gnt pre", m1_gnt, 0);
        tick();
        chk("release m1_gnt", m1_gnt, 1);
        chk("release m0_gnt", m0_gnt, 0);

        // idle: no requests, inputs busy
        do_reset();
        drive(0, 0, 1, 1, 32'hFFFF, 32'hEEEE, 32'h1111, 32'h2222, 32'h3333);
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk);
            chk($sformatf("idle%0d owner", i), owner, 0);
            chk($sformatf("idle%0d bus", i), Bus_addr | Bus_wdata, 0);
            chk($sformatf("idle%0d Bus_wen", i), Bus_wen, 0);
            tick();
        end

        // randomized traffic against the reference model
        do_reset();
        own = -1; streak = 0; last = 1;
        mrv[0] = 1'b0; mrv[1] = 1'b0; mrd[0] = 32'h0; mrd[1] = 32'h0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                rq[k] = ($urandom_range(0, 3) != 0);
                wn[k] = 1'($urandom_range(0, 1));
                ad[k] = $urandom;
                wd[k] = $urandom;
            end
            brd_v = $urandom;
            drive(rq[0], rq[1], wn[0], wn[1], ad[0], ad[1], wd[0], wd[1], brd_v);

            acc = 1'b0; e_baddr = 32'h0; e_bwdata = 32'h0; e_bwen = 1'b0; e_own = 2'b00;
            if (own >= 0) begin
                acc = rq[own];
                e_own = (own == 0) ? 2'b01 : 2'b10;
                if (acc) begin
                    e_baddr = ad[own]; e_bwdata = wd[own]; e_bwen = wn[own];
                end
            end
            @(negedge cpu_clk);
            chk($sformatf("rnd%0d owner", cyc), owner, e_own);
            chk($sformatf("rnd%0d gnt", cyc), {m1_gnt, m0_gnt}, e_own);
            chk($sformatf("rnd%0d Bus_addr", cyc), Bus_addr, e_baddr);
            chk($sformatf("rnd%0d Bus_wdata", cyc), Bus_wdata, e_bwdata);
            chk($sformatf("rnd%0d Bus_wen", cyc), Bus_wen, e_bwen);
            chk($sformatf("rnd%0d rvalid", cyc), {m1_rvalid, m0_rvalid}, {mrv[1], mrv[0]});
            chk($sformatf("rnd%0d m0_rdata", cyc), m0_rdata, mrd[0]);
            chk($sformatf("rnd%0d m1_rdata", cyc), m1_rdata, mrd[1]);

            if (own < 0) begin
                if (rq[0] && rq[1]) nxt = 1 - last;
                else if (rq[0]) nxt = 0;
                else if (rq[1]) nxt = 1;
                else nxt = -1;
            end else if (!rq[own]) begin
                nxt = rq[1 - own] ? 1 - own : -1;
            end else if (streak + 1 >= HOLD && rq[1 - own]) begin
                nxt = 1 - own;
            end else begin
                nxt = own;
            end
            mrv[0] = 1'b0; mrv[1] = 1'b0;
            if (acc && !wn[own]) begin
                mrv[own] = 1'b1;
                mrd[own] = brd_v;
            end
            streak = (nxt != own) ? 0 : streak + (acc ? 1 : 0);
            if (nxt >= 0) last = nxt;
            own = nxt;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8 (legal 1..255), giving the maximum consecutive accesses one master may make while the other master is requesting.
REQ-002 The block SHALL have port cpu_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port cpu_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports m0_req, m1_req, input, 1 bit each: the master requests the bus; held high until it no longer needs the bus.
REQ-005 The block SHALL have ports m0_wen, m1_wen, input, 1 bit each: write enable of the master's current access.
REQ-006 The block SHALL have ports m0_addr, m1_addr, m0_wdata, m1_wdata, input, 32 bits each: the master's access address and write data.
REQ-007 The block SHALL have ports m0_gnt, m1_gnt, output, 1 bit each: the master owns the bus this cycle (registered).
REQ-008 The block SHALL have ports m0_rdata, m1_rdata, output, 32 bits each: registered read data.
REQ-009 The block SHALL have ports m0_rvalid, m1_rvalid, output, 1 bit each: the rdata is valid this cycle (one-cycle pulse).
REQ-010 The block SHALL have ports Bus_addr, Bus_wdata, output, 32 bits each, and Bus_wen, output, 1 bit: the shared bus toward Bridge.
REQ-011 The block SHALL have port Bus_rdata, input, 32 bits: combinational read data from Bridge.
REQ-012 The block SHALL have port owner, output, 2 bits: 00 idle, 01 m0, 10 m1 (registered).

Function
REQ-013 The block SHALL implement the states IDLE, OWN0 and OWN1; mX_gnt=1 exactly in OWNx; owner SHALL be decoded from the state.
REQ-014 An access SHALL occur in any cycle with mX_gnt=1 and mX_req=1.
REQ-015 During an access, Bus_addr/Bus_wdata SHALL combinationally equal the owner's addr/wdata and Bus_wen SHALL equal owner wen.
REQ-016 Outside an access, Bus_addr=0, Bus_wdata=0 and Bus_wen=0.
REQ-017 For a read access (wen=0), Bus_rdata SHALL be registered into mX_rdata and mX_rvalid=1 SHALL be asserted the next cycle (1-cycle latency).
REQ-018 mX_rdata SHALL hold its value until the next read by that master.
REQ-019 A write access SHALL produce no rvalid.
REQ-020 From IDLE with exactly one req high, the next state SHALL be that master's OWN state, so gnt rises 1 cycle after req.
REQ-021 From IDLE with both reqs high, the master not served last SHALL win; the last-served pointer resets to m1, so m0 wins the first tie.
REQ-022 In OWNx with req dropped, the next state SHALL be OWN(other) if the other req=1, else IDLE (no idle gap on handover).
REQ-023 A hold counter (8 bits) SHALL clear on entry to OWNx and increment on each access.
REQ-024 When the owner makes an access with counter==HOLD_MAX-1 and the other req=1, the next state SHALL be OWN(other) even though the owner req stays high.
REQ-025 If the other req=0, the counter SHALL saturate at HOLD_MAX-1 and ownership SHALL continue.
REQ-026 A preempted master SHALL see gnt=0 and SHALL keep req high. It SHALL be re-granted by the rules of REQ-022 and REQ-024.
REQ-027 Last-served pointer SHALL update on every entry to OWN0/OWN1.
REQ-028 req toggling while not granted SHALL have no effect beyond arbitration; no request is latched.

Reset
REQ-029 While cpu_rst_n=0, the block SHALL force: state IDLE, gnt=0, owner=00, rvalid=0, rdata=0, counter=0, pointer=m1, Bus_wen=0, Bus_addr=0 and Bus_wdata=0, immediately (asynchronous).
REQ-030 Reset asserted mid-access SHALL abort that access with no rvalid; the first grant after release follows REQ-020 and REQ-021.

Verification
REQ-031 The bench SHALL check: m0_req=1, wen=0, addr=0x0000_0010, Bus_rdata=0x1234_5678 -> m0_gnt=1 at cycle+1, Bus_addr=0x10, m0_rdata=0x1234_5678 with m0_rvalid=1 at cycle+2.
REQ-032 The bench SHALL check: both reqs rise together after reset -> m0 granted. Drop m0_req -> m1_gnt=1 next cycle, no IDLE cycle between.
REQ-033 The bench SHALL check: HOLD_MAX=4, m0 streaming, m1_req=1 -> exactly 4 m0 accesses, then m1_gnt=1. m1 drops -> m0_gnt=1 next cycle.
REQ-034 The bench SHALL check: m1 only, 20 writes (wen=1, wdata=0xA5A5_0000+i) -> Bus_wen=1 each cycle, no preemption, no rvalid.
REQ-035 The bench SHALL check: cpu_rst_n=0 mid-read -> gnt, rvalid, Bus_wen=0 within the same cycle. Release with m1_req=1 only -> m1_gnt at cycle+1.
REQ-036 The bench SHALL check: no req for 10 cycles -> owner=00, all Bus_* outputs=0.
